// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine on a borrowed ALU; done 35 cycles after start, divide-by-zero in 2.
// Each RUN cycle without alu_gnt stalls the iteration by one cycle; start is ignored while busy.
module muldiv_sequencer #(
    parameter logic [2:0] ALU_ADD_CTRL = 3'd2,
    parameter logic [2:0] ALU_SUB_CTRL = 3'd6,
    parameter logic [5:0] ALU_FUNC     = 6'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_data_a,
    output logic [31:0] alu_data_b,
    output logic [2:0]  alu_control,
    output logic [5:0]  alu_func,
    input  logic [31:0] alu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic        r_sign_p;
    logic        r_sign_r;
    logic [31:0] r_acc;    // multiply accumulator / divide remainder
    logic [31:0] r_mq;     // multiplier shift register / quotient
    logic [31:0] r_mcand;  // multiplicand / divisor magnitude
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;
    logic        r_alu_req;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_div;
    logic        w_signed;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_rs_sh;
    logic        w_rem_out;
    logic        w_sub_ok;
    logic        w_carry;
    logic [31:0] w_op_a;
    logic [2:0]  w_ctrl;
    logic [63:0] w_prod;
    logic [63:0] w_prod_neg;

    assign w_is_div   = r_op[1];
    assign w_signed   = r_op[0];
    assign w_rs_mag   = (w_signed && r_rs[31]) ? (32'd0 - r_rs) : r_rs;
    assign w_rt_mag   = (w_signed && r_rt[31]) ? (32'd0 - r_rt) : r_rt;
    assign w_rs_sh    = {r_acc[30:0], r_mq[31]};
    assign w_rem_out  = r_acc[31];
    assign w_sub_ok   = w_rem_out || (w_rs_sh >= r_mcand);
    assign w_carry    = (alu_result < r_acc);
    assign w_op_a     = w_is_div ? w_rs_sh : r_acc;
    assign w_ctrl     = w_is_div ? ALU_SUB_CTRL : ALU_ADD_CTRL;
    assign w_prod     = {r_acc, r_mq};
    assign w_prod_neg = 64'd0 - w_prod;

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign alu_req     = r_alu_req;
    assign alu_data_a  = r_alu_req ? w_op_a   : 32'd0;
    assign alu_data_b  = r_alu_req ? r_mcand  : 32'd0;
    assign alu_control = r_alu_req ? w_ctrl   : 3'd0;
    assign alu_func    = r_alu_req ? ALU_FUNC : 6'd0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= 2'd0;
            r_rs      <= 32'd0;
            r_rt      <= 32'd0;
            r_sign_p  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_acc     <= 32'd0;
            r_mq      <= 32'd0;
            r_mcand   <= 32'd0;
            r_cnt     <= 5'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_alu_req <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_rs    <= rs_data;
                        r_rt    <= rt_data;
                        r_dbz   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_sign_p <= w_signed & (r_rs[31] ^ r_rt[31]);
                    r_sign_r <= w_signed & r_rs[31];
                    if (w_is_div && (r_rt == 32'd0)) begin
                        r_dbz   <= 1'b1;
                        r_hi    <= r_rs;
                        r_lo    <= 32'hFFFF_FFFF;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_acc     <= 32'd0;
                        r_mq      <= w_is_div ? w_rs_mag : w_rt_mag;
                        r_mcand   <= w_is_div ? w_rt_mag : w_rs_mag;
                        r_cnt     <= 5'd0;
                        r_alu_req <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (alu_gnt) begin
                        if (w_is_div) begin
                            r_acc <= w_sub_ok ? alu_result : w_rs_sh;
                            r_mq  <= {r_mq[30:0], w_sub_ok};
                        end else if (r_mq[0]) begin
                            // 65-bit {carry,sum,mq} shifted right by one
                            r_acc <= {w_carry, alu_result[31:1]};
                            r_mq  <= {alu_result[0], r_mq[31:1]};
                        end else begin
                            r_acc <= {1'b0, r_acc[31:1]};
                            r_mq  <= {r_acc[0], r_mq[31:1]};
                        end
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_alu_req <= 1'b0;
                            r_state   <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (w_is_div) begin
                        r_lo <= r_sign_p ? (32'd0 - r_mq)  : r_mq;
                        r_hi <= r_sign_r ? (32'd0 - r_acc) : r_acc;
                    end else begin
                        {r_hi, r_lo} <= r_sign_p ? w_prod_neg : w_prod;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_alu_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with a behavioural add/sub ALU.
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        alu_gnt = 1'b1;
    logic        busy, done, div_by_zero, alu_req;
    logic [31:0] hi, lo, alu_data_a, alu_data_b, alu_result;
    logic [2:0]  alu_control;
    logic [5:0]  alu_func;

    int checks = 0;
    int errors = 0;
    int last_busy_cnt;
    int last_done_cyc;
    bit last_req_seen;
    int last_hold_err;
    int last_low_cnt;

    always #5 clock = ~clock;

    assign alu_result = (alu_control == 3'd2) ? (alu_data_a + alu_data_b) :
                        (alu_control == 3'd6) ? (alu_data_a - alu_data_b) : 32'd0;

    muldiv_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .alu_req     (alu_req),
        .alu_gnt     (alu_gnt),
        .alu_data_a  (alu_data_a),
        .alu_data_b  (alu_data_b),
        .alu_control (alu_control),
        .alu_func    (alu_func),
        .alu_result  (alu_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Cycle n is the cycle following the n-th edge after start was sampled.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit gate, input int abort_at);
        int cyc;
        int rk;
        bit pend;
        logic [31:0] sa, sb;
        @(negedge clock);
        op = o; rs_data = a; rt_data = b; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1; rk = 0; pend = 1'b0; sa = 32'd0; sb = 32'd0;
        last_done_cyc = -1; last_busy_cnt = 0; last_req_seen = 1'b0;
        last_hold_err = 0; last_low_cnt = 0;
        while (last_done_cyc < 0 && cyc < 200) begin
            if (alu_req) begin
                last_req_seen = 1'b1;
                if (gate) alu_gnt = rk[0];
                rk++;
                if (pend && (alu_data_a !== sa || alu_data_b !== sb)) last_hold_err++;
                pend = gate && !alu_gnt;
                if (pend) last_low_cnt++;
                sa = alu_data_a;
                sb = alu_data_b;
            end else begin
                alu_gnt = 1'b1;
            end
            if (busy) last_busy_cnt++;
            if (done) last_done_cyc = cyc;
            if (gate && cyc == 20) begin start = 1'b1; op = 2'b10; rs_data = 32'd9; end
            if (gate && cyc == 22) start = 1'b0;
            if (abort_at > 0 && cyc == abort_at) reset = 1'b0;
            if (abort_at > 0 && cyc == abort_at + 1) begin
                reset = 1'b1;
                break;
            end
            if (last_done_cyc < 0) begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        start = 1'b0;
        alu_gnt = 1'b1;
    endtask

    task automatic exec(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit gate, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit exp_dbz);
        run_op(o, a, b, gate, 0);
        check({tag, "_done_cycle"}, last_done_cyc, exp_cyc);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_dbz"}, div_by_zero, exp_dbz);
        @(posedge clock); #1;
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        check("rst_req", alu_req, 1'b0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_alu_a", alu_data_a, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        exec("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 35, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        check("multu_busy_cycles", last_busy_cnt, 35);
        check("multu_req_seen", last_req_seen, 1'b1);

        exec("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 35, 32'h4000_0000, 32'h0, 1'b0);
        exec("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 35, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        exec("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        exec("divu", 2'b10, 32'd100, 32'd7, 1'b0, 35, 32'd2, 32'd14, 1'b0);
        exec("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 35, 32'd0, 32'h8000_0000, 1'b0);

        exec("divu_zero", 2'b10, 32'd5, 32'd0, 1'b0, 2, 32'd5, 32'hFFFF_FFFF, 1'b1);
        check("divu_zero_req", last_req_seen, 1'b0);
        check("divu_zero_busy_cycles", last_busy_cnt, 2);
        check("divu_zero_sticky", div_by_zero, 1'b1);
        exec("divu_after_zero", 2'b10, 32'd100, 32'd7, 1'b0, 35, 32'd2, 32'd14, 1'b0);

        exec("multu_gated", 2'b00, 32'd6, 32'd7, 1'b1, 67, 32'd0, 32'd42, 1'b0);
        check("gated_hold", last_hold_err, 0);
        check("gated_low_cycles", last_low_cnt, 32);

        exec("mult_prep", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 35, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(2'b00, 32'd3, 32'd5, 1'b0, 10);
        check("abort_no_done", last_done_cyc, -1);
        check("abort_busy", busy, 1'b0);
        check("abort_req", alu_req, 1'b0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(posedge clock); #1;
        exec("after_abort", 2'b00, 32'd6, 32'd7, 1'b0, 35, 32'd0, 32'd42, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller that executes MULT/MULTU/DIV/DIVU in the EX stage by iterating the shared 32-bit ALU: shift-add for multiply, restoring shift-subtract for divide.
- Borrows the ALU through a request/grant handshake with the EX-stage issue logic.
- Holds the HI/LO result registers.
- Asserts busy so the hazard unit can stall dependent instructions.

Parameters:
- ALU_ADD_CTRL, 3'd2, alu_control code the ALU decodes as 32-bit add.
- ALU_SUB_CTRL, 3'd6, alu_control code the ALU decodes as 32-bit subtract (data_a - data_b).
- ALU_FUNC, 6'd0, func value driven alongside the control code.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  operation request; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs_data  input  32  multiplicand / dividend.
- rt_data  input  32  multiplier / divisor.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when hi/lo are updated.
- div_by_zero  output  1  sticky until next accepted start; set by DIV/DIVU with rt_data=0.
- hi  output  32  HI register.
- lo  output  32  LO register.
- alu_req  output  1  ALU ownership request; high only in RUN.
- alu_gnt  input  1  ALU granted this cycle.
- alu_data_a  output  32  ALU operand A; 0 when alu_req low.
- alu_data_b  output  32  ALU operand B; 0 when alu_req low.
- alu_control  output  3  ALU op code; 0 when alu_req low.
- alu_func  output  6  ALU_FUNC when alu_req high, else 0.
- alu_result  input  32  ALU result, combinational, same cycle.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; busy, done, div_by_zero, alu_req = 0; hi=lo=0; counter=0. Reset mid-operation aborts it and does not update hi/lo beyond clearing them.
- States: IDLE, SETUP, RUN, FIX, DONE.
- IDLE: start=1 latches op, clears div_by_zero and goes to SETUP. start is ignored in all other states.
- SETUP (1 cycle):
  - Signed ops load operand magnitudes and record sign_p = rs[31]^rt[31] and sign_r = rs[31]. Unsigned ops load raw operands with both signs 0.
  - For DIV/DIVU with rt=0: set div_by_zero, hi=rs_data (as latched), lo=32'hFFFFFFFF, go to DONE.
  - Otherwise counter=0 and go to RUN.
- RUN: alu_req=1. The iteration advances only on cycles with alu_gnt=1; with alu_gnt=0 all state holds and the ALU outputs stay driven.
- Multiply iteration (registers acc, mq, mcand):
  - a=acc, b=mcand, ctrl=ALU_ADD_CTRL.
  - If mq[0]: carry=(alu_result < acc) unsigned, and {acc,mq} = {carry,alu_result,mq[31:1]}.
  - Else {acc,mq} = {1'b0,acc,mq[31:1]}.
- Divide iteration (registers rem, quot, dvsr):
  - rs_sh={rem[30:0],quot[31]}, out=rem[31].
  - a=rs_sh, b=dvsr, ctrl=ALU_SUB_CTRL.
  - If out or rs_sh>=dvsr: rem=alu_result and quot={quot[30:0],1}.
  - Else rem=rs_sh and quot={quot[30:0],0}.
- After the granted iteration with counter=31, go to FIX. The counter wraps to 0.
- FIX (1 cycle):
  - Multiply: {hi,lo} = sign_p ? -{acc,mq} (64-bit two's complement) : {acc,mq}.
  - Divide: lo = sign_p ? -quot : quot; hi = sign_r ? -rem : rem.
- DONE (1 cycle): done=1, then IDLE. hi/lo are valid from the DONE cycle onward and hold until the next FIX or divide-by-zero.
- Latency, with alu_gnt held high:
  - done is high 35 cycles after the start-sampling cycle (cycle 0).
  - Each cycle with alu_gnt low in RUN adds exactly 1.
  - Divide-by-zero: done at cycle 2.
- Overflow: DIV of 0x80000000 by 0xFFFFFFFF yields lo=0x80000000, hi=0, with no flag.

Test Plan:
- MULTU rs=rt=32'hFFFFFFFF, gnt=1 -> done at cycle 35, hi=32'hFFFFFFFE, lo=32'h00000001, busy high cycles 1-35.
- MULT rs=32'h80000000, rt=32'h80000000 -> hi=32'h40000000, lo=0; MULT rs=-3, rt=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV rs=-7, rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIVU rs=5, rt=0 -> done at cycle 2, div_by_zero=1, hi=5, lo=32'hFFFFFFFF, alu_req never high; next start clears div_by_zero.
- MULTU 6*7 with alu_gnt low on alternate RUN cycles -> done at cycle 67, lo=42, hi=0; ALU outputs held while gnt low; start pulses during busy are ignored.
- Start MULTU, then assert reset=0 at cycle 10 -> next edge: busy=0, alu_req=0, hi=lo=0, state IDLE; a fresh op afterwards completes normally.
